// File: rtl/sram22_pipe_model_if.sv
// Request/response bundle for the sram22 single-port macro model.
// The master drives requests; the slave (the memory) drives read data and busy.
interface sram22_pipe_model_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WMASK_WIDTH = 4
);
    logic                   ce;
    logic                   we;
    logic [WMASK_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  din;
    logic                   clr;
    logic [DATA_WIDTH-1:0]  dout;
    logic                   dout_valid;
    logic                   busy;

    modport master (
        output ce, we, wmask, addr, din, clr,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  ce, we, wmask, addr, din, clr,
        output dout, dout_valid, busy
    );
endinterface

// File: rtl/sram22_pipe_model.sv
// Behavioural single-port SRAM for the sram22 family: lane-masked writes,
// 1- or 2-cycle read latency with a valid strobe, and a full-array clear engine.
module sram22_pipe_model #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 9,
    parameter int                    WMASK_WIDTH  = 4,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input logic                clk,
    input logic                rst,
    sram22_pipe_model_if.slave bus
);
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(DEPTH - 1);

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_wmask
        $error("sram22_pipe_model: WMASK_WIDTH must divide DATA_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram22_pipe_model: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {CLEAR, READY} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   clear_wr, req_wr, req_rd;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DATA_WIDTH-1:0]  pipe_data;
    logic                   pipe_valid;
    logic [DATA_WIDTH-1:0]  dout_q;
    logic                   dout_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clr in READY takes priority and silently drops the same-cycle request.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_wr = 1'b0;
        req_wr   = 1'b0;
        req_rd   = 1'b0;
        if (!rst) begin
            case (state_q)
                CLEAR: begin
                    clear_wr = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) state_d = READY;
                end
                READY: begin
                    if (bus.clr) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else if (bus.ce) begin
                        req_wr = bus.we;
                        req_rd = !bus.we;
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear_wr) begin
            mem[cnt_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
        end else if (req_wr) begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (bus.wmask[i]) begin
                    mem[bus.addr][i*LANE_WIDTH +: LANE_WIDTH] <= bus.din[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // The extra stage captures the array at the request edge, so a write one
    // cycle later cannot alter data already in flight.
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] stage_data;
        logic                  stage_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_valid <= 1'b0;
            end else begin
                stage_valid <= req_rd;
                if (req_rd) stage_data <= mem[bus.addr];
            end
        end

        assign pipe_data  = stage_data;
        assign pipe_valid = stage_valid;
    end else begin : g_lat1
        assign pipe_data  = mem[bus.addr];
        assign pipe_valid = req_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= pipe_valid;
            if (pipe_valid) dout_q <= pipe_data;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q == CLEAR);
endmodule

// File: tb/tb_sram22_pipe_model.sv
// Scoreboard bench for sram22_pipe_model: one instance per read latency,
// directed requests push expected read data, negedge monitors pop and compare.
module tb_sram22_pipe_model;
    logic clk = 1'b0;
    logic rst1, rst2;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];

    always #5 clk = ~clk;

    sram22_pipe_model_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(4)) if1 ();
    sram22_pipe_model_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(4)) if2 ();

    sram22_pipe_model #(
        .DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(4),
        .READ_LATENCY(1), .INIT_VALUE(32'h0000_0000)
    ) u_lat1 (.clk(clk), .rst(rst1), .bus(if1.slave));

    sram22_pipe_model #(
        .DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(4),
        .READ_LATENCY(2), .INIT_VALUE(32'h0BAD_F00D)
    ) u_lat2 (.clk(clk), .rst(rst2), .bus(if2.slave));

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Every dout_valid must match a queued expectation, in issue order.
    always @(negedge clk) begin
        if (if1.dout_valid !== 1'b0) begin
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL lat1_unexpected_valid got dout_valid=%b exp=0", if1.dout_valid);
            end else begin
                check_output("lat1_rd_data", if1.dout, exp_q1.pop_front());
            end
        end
        if (if2.dout_valid !== 1'b0) begin
            if (exp_q2.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL lat2_unexpected_valid got dout_valid=%b exp=0", if2.dout_valid);
            end else begin
                check_output("lat2_rd_data", if2.dout, exp_q2.pop_front());
            end
        end
    end

    task automatic apply_stimulus(input bit sel2, input logic ce, input logic we, input logic clr,
                                  input logic [3:0] mask, input logic [8:0] addr, input logic [31:0] din);
        if (sel2) begin
            if2.ce = ce; if2.we = we; if2.clr = clr; if2.wmask = mask; if2.addr = addr; if2.din = din;
        end else begin
            if1.ce = ce; if1.we = we; if1.clr = clr; if1.wmask = mask; if1.addr = addr; if1.din = din;
        end
        @(posedge clk);
        #1;
        if (sel2) begin
            if2.ce = 1'b0; if2.we = 1'b0; if2.clr = 1'b0;
        end else begin
            if1.ce = 1'b0; if1.we = 1'b0; if1.clr = 1'b0;
        end
    endtask

    task automatic do_write(input bit sel2, input logic [8:0] addr, input logic [31:0] din, input logic [3:0] mask);
        apply_stimulus(sel2, 1'b1, 1'b1, 1'b0, mask, addr, din);
    endtask

    task automatic do_read(input bit sel2, input logic [8:0] addr, input bit push, input logic [31:0] exp);
        if (push) begin
            if (sel2) exp_q2.push_back(exp);
            else      exp_q1.push_back(exp);
        end
        apply_stimulus(sel2, 1'b1, 1'b0, 1'b0, 4'h0, addr, 32'h0);
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut(input bit sel2, input int cycles);
        if (sel2) rst2 = 1'b1; else rst1 = 1'b1;
        do_idle(cycles);
        if (sel2) begin
            check_output("lat2_rst_dout", if2.dout, 32'h0);
            check_output("lat2_rst_valid", {31'b0, if2.dout_valid}, 32'h0);
            check_output("lat2_rst_busy", {31'b0, if2.busy}, 32'h1);
            rst2 = 1'b0;
        end else begin
            check_output("lat1_rst_dout", if1.dout, 32'h0);
            check_output("lat1_rst_valid", {31'b0, if1.dout_valid}, 32'h0);
            check_output("lat1_rst_busy", {31'b0, if1.busy}, 32'h1);
            rst1 = 1'b0;
        end
    endtask

    task automatic wait_clear(input bit sel2, input int expected, input string name);
        int n = 0;
        while ((sel2 ? if2.busy : if1.busy) === 1'b1 && n < 5000) begin
            n++;
            @(posedge clk);
            #1;
        end
        check_output(name, n, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        if1.ce = 1'b0; if1.we = 1'b0; if1.clr = 1'b0; if1.wmask = '0; if1.addr = '0; if1.din = '0;
        if2.ce = 1'b0; if2.we = 1'b0; if2.clr = 1'b0; if2.wmask = '0; if2.addr = '0; if2.din = '0;

        // Latency 1: requests during the sweep are dropped, two sweep cycles consumed.
        reset_dut(1'b0, 2);
        do_write(1'b0, 9'd3, 32'hFFFF_FFFF, 4'hF);
        do_read(1'b0, 9'd3, 1'b0, 32'h0);
        wait_clear(1'b0, 510, "lat1_clear_cycles");
        do_read(1'b0, 9'd0, 1'b1, 32'h0);
        check_output("lat1_valid_latency", {31'b0, if1.dout_valid}, 32'h1);
        do_read(1'b0, 9'd255, 1'b1, 32'h0);
        do_read(1'b0, 9'd511, 1'b1, 32'h0);
        do_read(1'b0, 9'd3, 1'b1, 32'h0);
        do_write(1'b0, 9'd5, 32'hDEAD_BEEF, 4'b0101);
        do_write(1'b0, 9'd5, 32'h1122_3344, 4'b1010);
        do_write(1'b0, 9'd5, 32'h0000_0000, 4'b0000);
        do_read(1'b0, 9'd5, 1'b1, 32'h11AD_33EF);
        do_write(1'b0, 9'd9, 32'h1234_5678, 4'hF);
        do_read(1'b0, 9'd9, 1'b1, 32'h1234_5678);
        do_idle(3);

        // Latency 2: in-flight data is immune to a following write.
        reset_dut(1'b1, 1);
        wait_clear(1'b1, 512, "lat2_clear_cycles");
        do_read(1'b1, 9'd0, 1'b1, 32'h0BAD_F00D);
        do_write(1'b1, 9'd7, 32'hA5A5_A5A5, 4'hF);
        do_read(1'b1, 9'd7, 1'b1, 32'hA5A5_A5A5);
        check_output("lat2_valid_not_early", {31'b0, if2.dout_valid}, 32'h0);
        do_write(1'b1, 9'd7, 32'h0000_0000, 4'hF);
        check_output("lat2_valid_on_time", {31'b0, if2.dout_valid}, 32'h1);
        do_read(1'b1, 9'd7, 1'b1, 32'h0000_0000);

        // clr with a read in flight: the read completes, the same-cycle read is dropped.
        do_write(1'b1, 9'd20, 32'hCAFE_F00D, 4'hF);
        do_read(1'b1, 9'd20, 1'b1, 32'hCAFE_F00D);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 9'd20, 32'h0);
        check_output("lat2_clr_read_completes", {31'b0, if2.dout_valid}, 32'h1);
        wait_clear(1'b1, 512, "lat2_clr_cycles");
        do_read(1'b1, 9'd20, 1'b1, 32'h0BAD_F00D);
        do_idle(3);

        // Reset one cycle after a read issue kills it and restarts the sweep.
        do_write(1'b1, 9'd7, 32'h55AA_55AA, 4'hF);
        do_read(1'b1, 9'd7, 1'b1, 32'h55AA_55AA);
        do_idle(2);
        do_read(1'b1, 9'd7, 1'b0, 32'h0);
        reset_dut(1'b1, 1);
        wait_clear(1'b1, 512, "lat2_rst_clear_cycles");
        do_read(1'b1, 9'd7, 1'b1, 32'h0BAD_F00D);
        do_idle(4);

        check_output("lat1_queue_drained", exp_q1.size(), 32'h0);
        check_output("lat2_queue_drained", exp_q2.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
